scmp_dad_seq: RTL

Multi-cycle sequencer that performs the SC/MP decimal add (DAD) using the shared 8-bit binary ALU. The ALU's decimal-adjust op is not used.
- Issues a binary ADD, then up to two correction ADDs (+0x06, +0x60) through the ALU.
- Requests the ALU via a req/gnt handshake, since the ALU is shared with the main microcode datapath.
- Returns the BCD result and the new CY/L to the microcode controller.
- Never touches OV.

---
 rtl/scmp_dad_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/scmp_dad_seq.sv
// SC/MP decimal-add sequencer: runs a binary ADD plus up to two BCD correction
// ADDs through the shared 8-bit ALU, negotiating ownership with req/gnt.
package scmp_alu_pkg;
  typedef enum logic [2:0] {
    ALU_OP_NUL = 3'd0,
    ALU_OP_ADD = 3'd1,
    ALU_OP_SUB = 3'd2,
    ALU_OP_AND = 3'd3,
    ALU_OP_OR  = 3'd4,
    ALU_OP_XOR = 3'd5,
    ALU_OP_DA  = 3'd6
  } ALU_OP_t;
endpackage

module scmp_dad_seq
  import scmp_alu_pkg::*;
#(
  parameter bit SKIP_NULL_ADJ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cy_i,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_o,
  output logic       cy_o,
  output logic       alu_req,
  input  logic       alu_gnt,
  output ALU_OP_t    alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cy,
  input  logic [7:0] alu_res,
  input  logic       alu_cy_res
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADD    = 3'd1;
  localparam logic [2:0] S_ADJ_LO = 3'd2;
  localparam logic [2:0] S_ADJ_HI = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, s_q, s_d, res_q, res_d;
  logic       cy_q, cy_d, c1_q, c1_d, lo_fix_q, lo_fix_d, hi_fix_q, hi_fix_d;
  logic       cyo_q, cyo_d;
  logic       lo_now, hi_now;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    s_d      = s_q;
    c1_d     = c1_q;
    lo_fix_d = lo_fix_q;
    hi_fix_d = hi_fix_q;
    res_d    = res_q;
    cyo_d    = cyo_q;
    lo_now   = 1'b0;
    hi_now   = 1'b0;
    alu_req  = 1'b0;
    alu_op   = ALU_OP_NUL;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_cy   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a_i;
          b_d      = b_i;
          cy_d     = cy_i;
          s_d      = 8'h00;
          c1_d     = 1'b0;
          lo_fix_d = 1'b0;
          hi_fix_d = 1'b0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        alu_req = 1'b1;
        alu_op  = ALU_OP_ADD;
        alu_a   = a_q;
        alu_b   = b_q;
        alu_cy  = cy_q;
        if (alu_gnt) begin
          // half-carry out of bit 3 is recovered from the operands and the sum
          lo_now   = (a_q[4] ^ b_q[4] ^ alu_res[4]) | (alu_res[3:0] > 4'd9);
          hi_now   = alu_cy_res | (alu_res[7:4] > 4'd9);
          s_d      = alu_res;
          c1_d     = alu_cy_res;
          lo_fix_d = lo_now;
          hi_fix_d = hi_now;
          if (lo_now || !SKIP_NULL_ADJ) begin
            state_d = S_ADJ_LO;
          end else if (hi_now) begin
            state_d = S_ADJ_HI;
          end else begin
            res_d   = alu_res;
            cyo_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_ADJ_LO: begin
        alu_req = 1'b1;
        alu_op  = ALU_OP_ADD;
        alu_a   = s_q;
        alu_b   = lo_fix_q ? 8'h06 : 8'h00;
        if (alu_gnt) begin
          hi_now   = c1_q | alu_cy_res | (alu_res[7:4] > 4'd9);
          s_d      = alu_res;
          hi_fix_d = hi_now;
          if (hi_now || !SKIP_NULL_ADJ) begin
            state_d = S_ADJ_HI;
          end else begin
            res_d   = alu_res;
            cyo_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_ADJ_HI: begin
        alu_req = 1'b1;
        alu_op  = ALU_OP_ADD;
        alu_a   = s_q;
        alu_b   = hi_fix_q ? 8'h60 : 8'h00;
        if (alu_gnt) begin
          s_d     = alu_res;
          res_d   = alu_res;
          cyo_d   = hi_fix_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cy_q     <= 1'b0;
      s_q      <= 8'h00;
      c1_q     <= 1'b0;
      lo_fix_q <= 1'b0;
      hi_fix_q <= 1'b0;
      res_q    <= 8'h00;
      cyo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cy_q     <= cy_d;
      s_q      <= s_d;
      c1_q     <= c1_d;
      lo_fix_q <= lo_fix_d;
      hi_fix_q <= hi_fix_d;
      res_q    <= res_d;
      cyo_q    <= cyo_d;
    end
  end

  assign busy  = (state_q == S_ADD) || (state_q == S_ADJ_LO) || (state_q == S_ADJ_HI);
  assign done  = (state_q == S_DONE);
  assign res_o = res_q;
  assign cy_o  = cyo_q;

endmodule
